// File: rtl/ula_seq_ctrl_if.sv
// Command/response handshake bundle for the ULA sequencing controller.
// master = command source and response consumer, slave = controller.
interface ula_seq_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [3:0] rsp_flags;
    logic       rsp_err;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_a,
        output cmd_b,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_flags,
        input  rsp_err,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_a,
        input  cmd_b,
        output cmd_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_flags,
        output rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/ula_seq_ctrl.sv
// Sequencing controller for the 4-bit ULA: one command at a time, registered result.
// Optional shift-add 4x4 multiply on the ULA adder, enabled by ULA_SEQ_MUL_EN.
module ula_seq_ctrl (
    input  logic               clk,
    input  logic               rst_n,
    ula_seq_ctrl_if.slave      bus,
    output logic [3:0]         alu_a_out,
    output logic [3:0]         alu_b_out,
    output logic [2:0]         alu_op_out,
    input  logic [3:0]         alu_res_in,
    input  logic               alu_c_in,
    input  logic               alu_v_in,
    input  logic               alu_z_in,
    input  logic               alu_n_in
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_ADD = 3'b100;

    logic [1:0] state_q;
    logic [1:0] state_d;

    logic [2:0] op_q;
    logic [3:0] a_q;
    logic [3:0] b_q;

    logic [7:0] rsp_data_q;
    logic [3:0] rsp_flags_q;
    logic       rsp_err_q;

    logic       cmd_fire;
    logic       op_is_ula;
    logic       op_is_mul;
    logic       mul_last;

    assign cmd_fire  = (state_q == S_IDLE) && bus.cmd_valid;
    assign op_is_ula = ~bus.cmd_op[3];

`ifdef ULA_SEQ_MUL_EN
    // Product register; bit 8 of the nominal 9-bit product is always zero
    // after a right shift, so only the low 8 bits are kept.
    logic [7:0] p_q;
    logic [1:0] cnt_q;
    logic [7:0] prod_next;

    assign op_is_mul = (bus.cmd_op == 4'b1000);
    assign prod_next = {alu_c_in, alu_res_in, p_q[3:1]};
    assign mul_last  = (state_q == S_MUL) && (cnt_q == 2'd3);
`else
    assign op_is_mul = 1'b0;
    assign mul_last  = 1'b0;
`endif

    // Next-state decode for the command/response sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    if (op_is_ula) begin
                        state_d = S_EXEC;
                    end else if (op_is_mul) begin
                        state_d = S_MUL;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_EXEC: state_d = S_DONE;
            S_MUL: begin
                if (mul_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the command operands when it is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= 3'b000;
            a_q  <= 4'h0;
            b_q  <= 4'h0;
        end else if (cmd_fire) begin
            op_q <= bus.cmd_op[2:0];
            a_q  <= bus.cmd_a;
            b_q  <= bus.cmd_b;
        end
    end

`ifdef ULA_SEQ_MUL_EN
    // Shift-add product and iteration count, one ULA add per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q   <= 8'h00;
            cnt_q <= 2'd0;
        end else if (cmd_fire && op_is_mul) begin
            p_q   <= {4'h0, bus.cmd_b};
            cnt_q <= 2'd0;
        end else if (state_q == S_MUL) begin
            p_q   <= prod_next;
            cnt_q <= cnt_q + 2'd1;
        end
    end
`endif

    // Response registers, loaded on the cycle that completes a command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q  <= 8'h00;
            rsp_flags_q <= 4'h0;
            rsp_err_q   <= 1'b0;
        end else if (cmd_fire && !op_is_ula && !op_is_mul) begin
            rsp_data_q  <= 8'h00;
            rsp_flags_q <= 4'h0;
            rsp_err_q   <= 1'b1;
        end else if (state_q == S_EXEC) begin
            rsp_data_q  <= {4'h0, alu_res_in};
            rsp_flags_q <= {alu_c_in, alu_v_in, alu_z_in, alu_n_in};
            rsp_err_q   <= 1'b0;
`ifdef ULA_SEQ_MUL_EN
        end else if (mul_last) begin
            rsp_data_q  <= prod_next;
            rsp_flags_q <= {2'b00, prod_next == 8'h00, prod_next[7]};
            rsp_err_q   <= 1'b0;
`endif
        end
    end

    // ULA operand drive: registered operands in EXEC, adder step in MUL
    always_comb begin
        alu_a_out  = 4'h0;
        alu_b_out  = 4'h0;
        alu_op_out = 3'b000;
        case (state_q)
            S_EXEC: begin
                alu_a_out  = a_q;
                alu_b_out  = b_q;
                alu_op_out = op_q;
            end
`ifdef ULA_SEQ_MUL_EN
            S_MUL: begin
                alu_a_out  = p_q[7:4];
                alu_b_out  = p_q[0] ? a_q : 4'h0;
                alu_op_out = OP_ADD;
            end
`endif
            default: begin
                alu_a_out  = 4'h0;
                alu_b_out  = 4'h0;
                alu_op_out = 3'b000;
            end
        endcase
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_DONE);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_flags = rsp_flags_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule
